// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver.
// Contents: the frame-sequencer state type, the default oversample ratio,
// the data-length constants, and a reference parity helper that the
// receiver uses to check incoming frames.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_7    = 7;
  localparam int unsigned DATA_BITS_8    = 8;

  // Parity over the low nbits of data; odd=1 gives odd parity.
  function automatic logic parity_calc(input logic [7:0] data,
                                       input int unsigned nbits,
                                       input logic odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_async_if.sv
// Host-side transmit handshake bundle for uart_tx_async.
//   tx_data  byte to send (bit 7 ignored in 7-bit mode)
//   tx_wr    write strobe, taken only while txrdy=1
//   txrdy    holding register empty
//   tx_busy  frame in progress
//   tx_done  one-cycle pulse at the end of the stop bit
interface uart_tx_async_if;
  import uart_pkg::*;

  logic [7:0] tx_data;
  logic       tx_wr;
  logic       txrdy;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_data, output tx_wr,
                  input  txrdy, input tx_busy, input tx_done);
  modport slave  (input  tx_data, input tx_wr,
                  output txrdy, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx_async.sv
// Double-buffered asynchronous UART transmitter.
// A 1-deep holding register feeds a shift sequencer that sends
// start / 7 or 8 data bits (LSB first) / optional parity / 1 stop bit.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   baud_en        oversample tick; all frame timing advances only on it
//   bit8           1 = 8 data bits, 0 = 7 data bits
//   parity_en      1 = append parity bit
//   odd_n_even     1 = odd parity, 0 = even parity
//   tx             registered serial line, idles high
//   bus            host handshake (tx_data, tx_wr, txrdy, tx_busy, tx_done)
module uart_tx_async
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_en,
  input  logic              bit8,
  input  logic              parity_en,
  input  logic              odd_n_even,
  output logic              tx,
  uart_tx_async_if.slave    bus
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  tx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       bit8_q, bit8_d;
  logic       pen_q, pen_d;
  logic       odd_q, odd_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic [2:0] bit_last;

  assign tx          = tx_q;
  assign bus.txrdy   = ~hold_full_q;
  assign bus.tx_done = done_q;
  // Busy covers the tx_done cycle even though the sequencer is already idle.
  assign bus.tx_busy = (state_q != IDLE) | done_q;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit8_d      = bit8_q;
    pen_d       = pen_q;
    odd_d       = odd_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    bit_last    = bit8_q ? 3'(DATA_BITS_8 - 1) : 3'(DATA_BITS_7 - 1);

    // A write on the frame-start cycle sees hold_full_q=1 and is dropped.
    if (bus.tx_wr && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (baud_en && hold_full_q) begin
          shift_d     = bit8 ? hold_q : {1'b0, hold_q[6:0]};
          hold_d      = '0;
          hold_full_d = 1'b0;
          bit8_d      = bit8;
          pen_d       = parity_en;
          odd_d       = odd_n_even;
          par_d       = 1'b0;
          tick_d      = '0;
          bit_d       = '0;
          tx_d        = 1'b0;
          state_d     = START;
        end
      end
      default: begin
        if (baud_en) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            case (state_q)
              START: begin
                tx_d    = shift_q[0];
                state_d = DATA;
              end
              DATA: begin
                // shift_q[0] is the bit on the line now; fold it into parity.
                par_d   = par_q ^ shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
                if (bit_q == bit_last) begin
                  bit_d = '0;
                  if (pen_q) begin
                    tx_d    = par_q ^ shift_q[0] ^ odd_q;
                    state_d = PARITY;
                  end else begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                  end
                end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
                end
              end
              PARITY: begin
                tx_d    = 1'b1;
                state_d = STOP;
              end
              STOP: begin
                tx_d    = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
              end
              default: state_d = IDLE;
            endcase
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      bit8_q      <= 1'b0;
      pen_q       <= 1'b0;
      odd_q       <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      bit8_q      <= bit8_d;
      pen_q       <= pen_d;
      odd_q       <= odd_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_async.sv
// Directed self-checking bench for uart_tx_async.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_async;

  logic clk = 1'b0;
  logic reset;
  logic baud_en;
  logic bit8;
  logic parity_en;
  logic odd_n_even;
  logic tx;

  uart_tx_async_if bus_if ();

  uart_tx_async #(.OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_en    (baud_en),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .tx         (tx),
    .bus        (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int div      = 1;
  int cyc_count = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; baud_en pulses once every div cycles.
  task automatic step();
    @(negedge clk);
    cyc_count++;
    baud_en = ((cyc_count % div) == 0);
  endtask

  task automatic do_write(input logic [7:0] d);
    bus_if.tx_data = d;
    bus_if.tx_wr   = 1'b1;
    step();
    bus_if.tx_wr   = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 64 * div) begin
      step();
      n++;
    end
    chk({tag, "_start"}, tx, 1'b0);
    chk({tag, "_rdy_after_load"}, bus_if.txrdy, 1'b1);
    chk({tag, "_busy"}, bus_if.tx_busy, 1'b1);
  endtask

  // exp_bits: frame bits LSB first, index 0 = start bit.
  task automatic observe_frame(input logic [15:0] exp_bits, input int nbits,
                               input int start_cyc, input string tag);
    int c = start_cyc;
    int dones = 0;
    int done_at = -1;
    int total = 16 * nbits * div;
    while (c < total) begin
      step();
      c++;
      if (bus_if.tx_done === 1'b1) begin
        dones++;
        done_at = c;
      end
      for (int b = 0; b < nbits; b++) begin
        if (c == (16 * b + 8) * div)
          chk($sformatf("%s_bit%0d", tag, b), tx, exp_bits[b]);
      end
    end
    chk({tag, "_busy_at_done"}, bus_if.tx_busy, 1'b1);
    chk({tag, "_done_count"}, dones, 1);
    chk({tag, "_done_cycle"}, done_at, total);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tx"}, tx, 1'b1);
    chk({tag, "_txrdy"}, bus_if.txrdy, 1'b1);
    chk({tag, "_busy"}, bus_if.tx_busy, 1'b0);
    chk({tag, "_done"}, bus_if.tx_done, 1'b0);
  endtask

  task automatic single_frame(input logic [7:0] d, input logic b8, input logic pen,
                              input logic odd, input logic [15:0] exp_bits,
                              input int nbits, input string tag);
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    do_write(d);
    chk({tag, "_rdy_after_wr"}, bus_if.txrdy, 1'b0);
    wait_start(tag);
    observe_frame(exp_bits, nbits, 0, tag);
    step();
    check_idle({tag, "_after"});
  endtask

  initial begin
    int lows;
    int dones;
    reset = 1'b1; baud_en = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    bus_if.tx_data = '0; bus_if.tx_wr = 1'b0;

    // Reset and idle with a toggling tick
    repeat (3) step();
    check_idle("reset");
    reset = 1'b0;
    div = 2;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i % 10 == 0) check_idle($sformatf("idle%0d", i));
    end

    // Full-rate tick frames
    div = 1;
    step();
    single_frame(8'h55, 1'b1, 1'b0, 1'b0, 16'h02AA, 10, "f8n1");
    single_frame(8'hA5, 1'b0, 1'b1, 1'b0, 16'h034A, 10, "f7e1");
    single_frame(8'hFF, 1'b1, 1'b1, 1'b1, 16'h07FE, 11, "f8o1");

    // Double buffering: 0x02 queued during frame 1, 0x03 dropped
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    do_write(8'h01);
    wait_start("buf1");
    do_write(8'h02);
    chk("buf_rdy_full", bus_if.txrdy, 1'b0);
    do_write(8'h03);
    observe_frame(16'h0202, 10, 2, "buf_f1");
    step();
    chk("buf_b2b_start", tx, 1'b0);
    observe_frame(16'h0204, 10, 0, "buf_f2");
    step();
    check_idle("buf_after");
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    chk("buf_no_third", lows, 0);

    // Slow tick, reset in data bit 3 with a byte waiting in holding
    div = 4;
    step();
    do_write(8'h3C);
    wait_start("slow");
    do_write(8'h99);
    chk("slow_hold_full", bus_if.txrdy, 1'b0);
    begin
      int c = 1;
      logic [15:0] exp_bits = 16'h0278;
      while (c < 288) begin
        step();
        c++;
        for (int b = 0; b < 5; b++) begin
          if (c == (16 * b + 8) * 4)
            chk($sformatf("slow_bit%0d", b), tx, exp_bits[b]);
        end
      end
    end
    reset = 1'b1;
    step();
    check_idle("midreset");
    reset = 1'b0;
    lows = 0;
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx !== 1'b1) lows++;
      if (bus_if.tx_done === 1'b1) dones++;
    end
    chk("midreset_no_frame", lows, 0);
    chk("midreset_no_done", dones, 0);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
